cm_arbiter_client: RTL and testbench

Requester-side front end for `cm_arbiter`. It buffers one pending item per channel and drives `cm_arbiter` with a request vector and aged weights. It collects the arbiter's grant after the arbiter's pipeline latency, pops the winning channel and presents its payload on a single valid/ready output. It sits between N producer channels and one shared consumer and closes the arbiter loop from the requester end.

---
 rtl/cm_pkg.sv | 25 ++
 rtl/cm_age_weight.sv | 46 ++++
 rtl/cm_arbiter_client.sv | 144 ++++++++++++++
 tb/tb_cm_arbiter_client.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared types for the cm arbiter family.
// Holds sort direction, client FSM states and a ceil-log2 helper.
package cm_pkg;

    typedef enum logic {
        SORT_MIN,
        SORT_MAX
    } t_sort_dir;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } t_cm_client_state;

    // Minimum of 1 so that a 2-entry index still gets one bit.
    function automatic int sclog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/cm_age_weight.sv
// Per-channel age counter with saturating effective weight.
// Age biases the base weight toward winning as a channel waits.
module cm_age_weight
    import cm_pkg::*;
#(
    parameter int        DWIDTH = 8,
    parameter int        AWIDTH = 4,
    parameter t_sort_dir DIR    = SORT_MIN
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [DWIDTH-1:0] i_prio,
    output logic [DWIDTH-1:0] o_weight
);

    logic [AWIDTH-1:0] age;
    logic [DWIDTH:0]   age_x;
    logic [DWIDTH:0]   sum;
    logic [DWIDTH:0]   dif;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age <= '0;
        end else if (i_clr) begin
            age <= '0;
        end else if (i_inc && age != '1) begin
            age <= age + AWIDTH'(1);
        end
    end

    assign age_x = (DWIDTH+1)'(age);
    assign sum   = {1'b0, i_prio} + age_x;
    assign dif   = {1'b0, i_prio} - age_x;

    // Extra top bit carries the overflow/borrow used for clamping.
    always_comb begin
        if (DIR == SORT_MIN) begin
            o_weight = dif[DWIDTH] ? '0 : dif[DWIDTH-1:0];
        end else begin
            o_weight = sum[DWIDTH] ? '1 : sum[DWIDTH-1:0];
        end
    end

endmodule

// File: rtl/cm_arbiter_client.sv
// cm_arbiter_client: requester-side front end for cm_arbiter.
// Buffers one item per channel, issues aged weights, returns the winner.
module cm_arbiter_client
    import cm_pkg::*;
#(
    parameter int        DCNT      = 4,
    parameter int        DWIDTH    = 8,
    parameter int        PWIDTH    = 16,
    parameter int        LAT       = 0,
    parameter t_sort_dir DIR       = SORT_MIN,
    parameter int        AWIDTH    = 4,
    localparam int       IDX_WIDTH = sclog2(DCNT)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DCNT-1:0]               i_vld,
    output logic [DCNT-1:0]               o_rdy,
    input  logic [DCNT-1:0][PWIDTH-1:0]   i_data,
    input  logic [DCNT-1:0][DWIDTH-1:0]   i_prio,
    output logic [DCNT-1:0]               o_req,
    output logic [DCNT-1:0][DWIDTH-1:0]   o_weight,
    input  logic                          i_gvld,
    input  logic [IDX_WIDTH-1:0]          i_gnt,
    output logic                          o_vld,
    input  logic                          i_rdy,
    output logic [PWIDTH-1:0]             o_data,
    output logic [IDX_WIDTH-1:0]          o_idx,
    output logic                          o_err
);

    localparam int CW = sclog2(LAT + 2);
    localparam int GN = 2 ** IDX_WIDTH;

    t_cm_client_state            state;
    logic [CW-1:0]               cnt;
    logic [DCNT-1:0]             held;
    logic [DCNT-1:0]             cap;
    logic [DCNT-1:0]             inc;
    logic [GN-1:0]               held_x;
    logic [DCNT-1:0][PWIDTH-1:0] data_q;
    logic [DCNT-1:0][DWIDTH-1:0] prio_q;
    logic [DCNT-1:0][DWIDTH-1:0] eff;
    logic                        samp;
    logic                        gnt_ok;
    logic                        fire;

    assign o_rdy  = ~held;
    assign cap    = i_vld & ~held;
    assign held_x = GN'(held);
    assign samp   = (state == ISSUE || state == WAIT) && cnt == CW'(LAT);
    // Out-of-range indices land on the zero padding of held_x.
    assign gnt_ok = i_gvld && held_x[i_gnt];
    assign fire   = samp && gnt_ok;

    always_comb begin
        inc = '0;
        for (int k = 0; k < DCNT; k++) begin
            inc[k] = fire && o_req[k] && (IDX_WIDTH'(k) != i_gnt);
        end
    end

    for (genvar k = 0; k < DCNT; k++) begin : g_age
        cm_age_weight #(
            .DWIDTH (DWIDTH),
            .AWIDTH (AWIDTH),
            .DIR    (DIR)
        ) u_age (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_clr    (cap[k]),
            .i_inc    (inc[k]),
            .i_prio   (prio_q[k]),
            .o_weight (eff[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            held     <= '0;
            data_q   <= '0;
            prio_q   <= '0;
            o_req    <= '0;
            o_weight <= '0;
            o_vld    <= 1'b0;
            o_data   <= '0;
            o_idx    <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            for (int k = 0; k < DCNT; k++) begin
                if (cap[k]) begin
                    held[k]   <= 1'b1;
                    data_q[k] <= i_data[k];
                    prio_q[k] <= i_prio[k];
                end
            end
            unique case (state)
                IDLE: begin
                    if (|held) begin
                        state    <= ISSUE;
                        cnt      <= '0;
                        o_req    <= held;
                        o_weight <= eff;
                    end
                end
                ISSUE, WAIT: begin
                    if (samp) begin
                        o_req    <= '0;
                        o_weight <= '0;
                        if (gnt_ok) begin
                            held[i_gnt] <= 1'b0;
                            o_data      <= data_q[i_gnt];
                            o_idx       <= i_gnt;
                            o_vld       <= 1'b1;
                            state       <= OUT;
                        end else begin
                            o_err <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= WAIT;
                    end
                end
                OUT: begin
                    if (i_rdy) begin
                        o_vld <= 1'b0;
                        if (|held) begin
                            state    <= ISSUE;
                            cnt      <= '0;
                            o_req    <= held;
                            o_weight <= eff;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm_arbiter_client.sv
// Scoreboard bench for cm_arbiter_client with a behavioural
// two-stage min-weight arbiter closing the loop.
module tb_cm_arbiter_client;
    import cm_pkg::*;

    localparam int DCNT = 4;
    localparam int DW   = 8;
    localparam int PW   = 16;
    localparam int IW   = 2;

    typedef struct {
        logic [IW-1:0] idx;
        logic [PW-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [DCNT-1:0]         i_vld = '0;
    logic [DCNT-1:0]         o_rdy;
    logic [DCNT-1:0][PW-1:0] i_data = '0;
    logic [DCNT-1:0][DW-1:0] i_prio = '0;
    logic [DCNT-1:0]         o_req;
    logic [DCNT-1:0][DW-1:0] o_weight;
    logic                    i_gvld;
    logic [IW-1:0]           i_gnt;
    logic                    o_vld;
    logic                    i_rdy = 1'b0;
    logic [PW-1:0]           o_data;
    logic [IW-1:0]           o_idx;
    logic                    o_err;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    int   hold_cnt = 0;
    int   rdy_delay = 0;
    bit   stall = 1'b0;
    bit   kill = 1'b0;
    bit   vld_q = 1'b0;

    logic [1:0]    pv = '0;
    logic [IW-1:0] pg0 = '0;
    logic [IW-1:0] pg1 = '0;

    always #5 clk = ~clk;

    cm_arbiter_client #(
        .DCNT   (DCNT),
        .DWIDTH (DW),
        .PWIDTH (PW),
        .LAT    (2),
        .DIR    (SORT_MIN),
        .AWIDTH (4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_vld    (i_vld),
        .o_rdy    (o_rdy),
        .i_data   (i_data),
        .i_prio   (i_prio),
        .o_req    (o_req),
        .o_weight (o_weight),
        .i_gvld   (i_gvld),
        .i_gnt    (i_gnt),
        .o_vld    (o_vld),
        .i_rdy    (i_rdy),
        .o_data   (o_data),
        .o_idx    (o_idx),
        .o_err    (o_err)
    );

    function automatic logic [IW-1:0] arb(input logic [DCNT-1:0] req,
                                          input logic [DCNT-1:0][DW-1:0] w);
        logic [IW-1:0] b;
        logic          f;
        b = '0;
        f = 1'b0;
        for (int k = 0; k < DCNT; k++) begin
            if (req[k] && (!f || w[k] < w[b])) begin
                b = IW'(k);
                f = 1'b1;
            end
        end
        return b;
    endfunction

    // Arbiter model: two register stages, not reset.
    always @(posedge clk) begin
        pv  <= {pv[0], |o_req};
        pg0 <= arb(o_req, o_weight);
        pg1 <= pg0;
    end
    assign i_gvld = pv[1] & ~kill;
    assign i_gnt  = pg1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int ch, input logic [PW-1:0] d,
                       input logic [DW-1:0] p);
        i_vld[ch]  = 1'b1;
        i_data[ch] = d;
        i_prio[ch] = p;
    endtask

    task automatic expect_out(input logic [IW-1:0] idx, input logic [PW-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || o_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Output consumer: ready after rdy_delay cycles of valid.
    always @(negedge clk) begin
        if (o_vld) begin
            i_rdy = !stall && hold_cnt >= rdy_delay;
            hold_cnt++;
        end else begin
            i_rdy = 1'b0;
            hold_cnt = 0;
        end
    end

    // Monitor: compare each new output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (o_err) err_seen++;
        if (o_vld && !vld_q) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 32'(o_idx), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("out_idx", 32'(o_idx), 32'(e.idx));
                chk("out_data", 32'(o_data), 32'(e.data));
            end
        end
        vld_q = o_vld;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(o_rdy), 32'hF);
        chk("rst_req", 32'(o_req), 32'h0);
        chk("rst_vld", 32'(o_vld), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_weight", 32'(o_weight), 32'h0);

        // Single channel latency
        rdy_delay = 0;
        put(2, 16'h00A5, 8'd7);
        expect_out(2'd2, 16'h00A5);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        chk("t2_rdy2_low", 32'(o_rdy[2]), 32'h0);
        chk("t2_req_early", 32'(o_req), 32'h0);
        @(negedge clk);
        chk("t2_req", 32'(o_req), 32'h4);
        chk("t2_weight", 32'(o_weight[2]), 32'd7);
        repeat (2) @(negedge clk);
        chk("t2_vld_early", 32'(o_vld), 32'h0);
        chk("t2_rdy2_hold", 32'(o_rdy[2]), 32'h0);
        @(negedge clk);
        chk("t2_vld", 32'(o_vld), 32'h1);
        chk("t2_idx", 32'(o_idx), 32'd2);
        chk("t2_data", 32'(o_data), 32'h00A5);
        drain();

        // Priority with aging: 9,3,3,5 -> 1,2,3,0
        put(0, 16'h0030, 8'd9);
        put(1, 16'h0031, 8'd3);
        put(2, 16'h0032, 8'd3);
        put(3, 16'h0033, 8'd5);
        expect_out(2'd1, 16'h0031);
        expect_out(2'd2, 16'h0032);
        expect_out(2'd3, 16'h0033);
        expect_out(2'd0, 16'h0030);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        drain();

        // Starvation: ch0 wins once its age reaches 15
        rdy_delay = 1;
        put(0, 16'h0040, 8'd15);
        put(1, 16'h0050, 8'd0);
        for (int k = 0; k < 15; k++) expect_out(2'd1, 16'h0050 + 16'(k));
        expect_out(2'd0, 16'h0040);
        expect_out(2'd1, 16'h005F);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        for (int r = 1; r <= 15; r++) begin
            n = 0;
            while (!o_rdy[1] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t4_refill_ready", 32'(o_rdy[1]), 32'h1);
            put(1, 16'h0050 + 16'(r), 8'd0);
            @(posedge clk);
            @(negedge clk);
            i_vld = '0;
        end
        drain();
        rdy_delay = 0;

        // Backpressure
        stall = 1'b1;
        put(3, 16'h0077, 8'd2);
        expect_out(2'd3, 16'h0077);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        n = 0;
        while (!o_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_vld_up", 32'(o_vld), 32'h1);
        put(0, 16'h0088, 8'd1);
        expect_out(2'd0, 16'h0088);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        chk("t5_rdy0_taken", 32'(o_rdy[0]), 32'h0);
        for (int c = 0; c < 10; c++) begin
            chk("t5_hold", 32'({o_vld, o_idx, o_data, o_req}),
                32'({1'b1, 2'd3, 16'h0077, 4'h0}));
            @(negedge clk);
        end
        stall = 1'b0;
        drain();

        // Bad grant: suppressed grant valid, then reissue
        kill = 1'b1;
        put(2, 16'h0099, 8'd4);
        expect_out(2'd2, 16'h0099);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        n = 0;
        while (!o_err && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_err_pulse", 32'(o_err), 32'h1);
        kill = 1'b0;
        chk("t6_held_kept", 32'(o_rdy), 32'hB);
        chk("t6_req_cleared", 32'(o_req), 32'h0);
        @(negedge clk);
        chk("t6_err_once", 32'(o_err), 32'h0);
        chk("t6_reissue", 32'(o_req), 32'h4);
        drain();
        chk("t6_err_total", 32'(err_seen), 32'd1);

        // Reset mid-WAIT discards the request
        put(1, 16'h0011, 8'd1);
        @(posedge clk);
        @(negedge clk);
        i_vld = '0;
        repeat (2) @(negedge clk);
        chk("t7_req_wait", 32'(o_req), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_rdy", 32'(o_rdy), 32'hF);
        chk("t7_rst_outs", 32'({o_req, o_vld, o_err, o_idx, o_data}), 32'h0);
        chk("t7_rst_weight", 32'(o_weight), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t7_no_out", 32'(o_vld), 32'h0);
        chk("t7_rdy_after", 32'(o_rdy), 32'hF);
        chk("t7_sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
